// File: rtl/pll_cfg_pkg.sv
// Shared constants, state encoding and frame classification for the PLL
// configuration writer.
package pll_cfg_pkg;

    localparam logic [3:0] OPC_WRITE   = 4'b0001;
    localparam int         FRAME_BITS  = 40;
    localparam int         STATUS_BITS = 4;
    localparam int         WORD_BITS   = 32;

    localparam int OPC_MSB  = 39;
    localparam int OPC_LSB  = 36;
    localparam int IDX_MSB  = 35;
    localparam int IDX_LSB  = 32;
    localparam int WORD_MSB = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LE_SETUP,
        ST_LE_PULSE
    } state_t;

    typedef enum logic [1:0] {
        CLS_WRITE,
        CLS_STATUS,
        CLS_BAD
    } frame_cls_t;

    // hdr is the opcode/index byte, frame bits [39:32].
    function automatic frame_cls_t classify(input logic [7:0] hdr,
                                            input logic [6:0] num,
                                            input int         pll_num);
        if (num == 7'(STATUS_BITS))
            return CLS_STATUS;
        if (num != 7'(FRAME_BITS))
            return CLS_BAD;
        if (hdr[7:4] != OPC_WRITE)
            return CLS_BAD;
        if (int'(hdr[3:0]) >= pll_num)
            return CLS_BAD;
        return CLS_WRITE;
    endfunction

endpackage

// File: rtl/pll_cfg_writer_sclk_tick_gen.sv
// Half-period timer for the PLL serial clock: one-cycle tick every HALF
// cycles, realigned whenever restart is pulsed.
import pll_cfg_pkg::*;

module sclk_tick_gen #(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int             CW     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= RELOAD;
        else if (restart || cnt == '0)
            cnt <= RELOAD;
        else
            cnt <= cnt - 1'b1;
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/pll_cfg_writer.sv
// Takes SPI command frames, validates them and writes the 32-bit word to the
// addressed PLL over a shared sclk/sdata bus with a per-PLL latch enable.
//
// state       | meaning
// ------------|-----------------------------------------------------------
// ST_IDLE     | waiting for dready with ack low
// ST_CHECK    | classify captured frame, load shifter or drop
// ST_SHIFT_LO | sclk low, current MSB on sdata
// ST_SHIFT_HI | sclk high, PLL samples sdata
// ST_LE_SETUP | sclk low settle before latch enable
// ST_LE_PULSE | selected pll_le high for LE_CYCLES
import pll_cfg_pkg::*;

module pll_cfg_writer #(
    parameter int CMD_BIT_NUM = 41,
    parameter int PLL_NUM     = 6,
    parameter int SCLK_HALF   = 4,
    parameter int LE_CYCLES   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CMD_BIT_NUM-1:0] data,
    input  logic [6:0]             data_num,
    input  logic                   dready,
    output logic                   ack,
    output logic                   pll_sclk,
    output logic                   pll_sdata,
    output logic [PLL_NUM-1:0]     pll_le,
    output logic                   busy,
    output logic [7:0]             err_count
);

    localparam int             LCW       = (LE_CYCLES > 1) ? $clog2(LE_CYCLES) : 1;
    localparam logic [LCW-1:0] LE_RELOAD = LCW'(LE_CYCLES - 1);

    state_t                  state;
    logic [FRAME_BITS-1:0]   frame_q;
    logic [6:0]              num_q;
    logic [3:0]              idx_q;
    logic [WORD_BITS-1:0]    shreg;
    logic [5:0]              bit_cnt;
    logic [LCW-1:0]          le_cnt;
    logic                    tick;
    logic                    tick_restart;
    frame_cls_t              cls;
    logic [PLL_NUM-1:0]      le_sel;

    // Bits above the 40-bit frame carry nothing for this block.
    if (CMD_BIT_NUM > FRAME_BITS) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^data[CMD_BIT_NUM-1:FRAME_BITS];
    end

    assign cls = classify(frame_q[OPC_MSB:IDX_LSB], num_q, PLL_NUM);

    // Realign the half-period timer on every bus-phase entry so each phase
    // lasts exactly SCLK_HALF cycles regardless of the free-running phase.
    assign tick_restart = (state == ST_CHECK) ||
                          (tick && (state == ST_SHIFT_LO ||
                                    state == ST_SHIFT_HI ||
                                    state == ST_LE_SETUP));

    always_comb begin
        le_sel = '0;
        for (int i = 0; i < PLL_NUM; i++)
            le_sel[i] = (idx_q == 4'(i));
    end

    sclk_tick_gen #(
        .HALF (SCLK_HALF)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (tick_restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            frame_q   <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            le_cnt    <= '0;
            ack       <= 1'b0;
            pll_sclk  <= 1'b0;
            pll_sdata <= 1'b0;
            pll_le    <= '0;
            busy      <= 1'b0;
            err_count <= '0;
        end else begin
            // ack handshake runs alongside the FSM; IDLE only re-arms once
            // dready has been seen low.
            if (!dready)
                ack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (dready && !ack) begin
                        frame_q <= data[FRAME_BITS-1:0];
                        num_q   <= data_num;
                        ack     <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    bit_cnt <= '0;
                    if (cls == CLS_WRITE) begin
                        shreg     <= frame_q[WORD_MSB:0];
                        idx_q     <= frame_q[IDX_MSB:IDX_LSB];
                        pll_sdata <= frame_q[WORD_MSB];
                        pll_sclk  <= 1'b0;
                        state     <= ST_SHIFT_LO;
                    end else begin
                        if (cls == CLS_BAD && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                ST_SHIFT_LO: begin
                    if (tick) begin
                        pll_sclk <= 1'b1;
                        state    <= ST_SHIFT_HI;
                    end
                end

                ST_SHIFT_HI: begin
                    if (tick) begin
                        pll_sclk <= 1'b0;
                        shreg    <= shreg << 1;
                        bit_cnt  <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'(WORD_BITS - 1)) begin
                            pll_sdata <= 1'b0;
                            state     <= ST_LE_SETUP;
                        end else begin
                            pll_sdata <= shreg[WORD_MSB-1];
                            state     <= ST_SHIFT_LO;
                        end
                    end
                end

                ST_LE_SETUP: begin
                    if (tick) begin
                        pll_le <= le_sel;
                        le_cnt <= LE_RELOAD;
                        state  <= ST_LE_PULSE;
                    end
                end

                ST_LE_PULSE: begin
                    if (le_cnt == '0) begin
                        pll_le  <= '0;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        le_cnt <= le_cnt - 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_cfg_writer.sv
// Self-checking bench for pll_cfg_writer: frame table plus corner sequences,
// with a bus monitor comparing completed transfers against a scoreboard.
module tb_pll_cfg_writer;

    localparam int CMD_BIT_NUM = 41;
    localparam int PLL_NUM     = 6;
    localparam int SCLK_HALF   = 4;
    localparam int LE_CYCLES   = 4;
    localparam int WRITE_LEN   = 1 + 64 * SCLK_HALF + SCLK_HALF + LE_CYCLES;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CMD_BIT_NUM-1:0] data;
    logic [6:0]             data_num;
    logic                   dready;
    logic                   ack;
    logic                   pll_sclk;
    logic                   pll_sdata;
    logic [PLL_NUM-1:0]     pll_le;
    logic                   busy;
    logic [7:0]             err_count;

    pll_cfg_writer #(
        .CMD_BIT_NUM (CMD_BIT_NUM),
        .PLL_NUM     (PLL_NUM),
        .SCLK_HALF   (SCLK_HALF),
        .LE_CYCLES   (LE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .data_num  (data_num),
        .dready    (dready),
        .ack       (ack),
        .pll_sclk  (pll_sclk),
        .pll_sdata (pll_sdata),
        .pll_le    (pll_le),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] word;
    } xfer_t;

    typedef struct {
        logic [CMD_BIT_NUM-1:0] d;
        logic [6:0]             n;
        bit                     wr;
        bit                     bad;
    } vec_t;

    xfer_t sb_q[$];
    int    n_total = 0;
    int    n_bad   = 0;
    int    exp_err = 0;

    int                 mon_bits  = 0;
    int                 mon_rises = 0;
    int                 mon_les   = 0;
    int                 le_len    = 0;
    logic [31:0]        mon_word  = '0;
    logic [PLL_NUM-1:0] le_mask   = '0;
    logic               prev_sclk = 1'b0;
    logic               prev_sdata = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: reassembles shifted words and checks them at LE fall.
    always @(negedge clk) begin
        if (!rst) begin
            mon_bits   = 0;
            mon_word   = '0;
            le_len     = 0;
            prev_sclk  = 1'b0;
            prev_sdata = 1'b0;
        end else begin
            if (pll_sclk && !prev_sclk) begin
                check("sdata_stable", 64'(pll_sdata), 64'(prev_sdata));
                mon_word = {mon_word[30:0], pll_sdata};
                mon_bits++;
                mon_rises++;
            end
            if (pll_le != '0) begin
                check("le_onehot", 64'($countones(pll_le)), 64'd1);
                if (le_len == 0) begin
                    check("bits_before_le", 64'(mon_bits), 64'd32);
                    le_mask = pll_le;
                end
                le_len++;
            end else if (le_len != 0) begin
                check("le_width", 64'(le_len), 64'(LE_CYCLES));
                mon_les++;
                if (sb_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_xfer: word 0x%0h le 0x%0h", mon_word, le_mask);
                end else begin
                    xfer_t e;
                    int    oi;
                    e  = sb_q.pop_front();
                    oi = -1;
                    for (int i = 0; i < PLL_NUM; i++)
                        if (le_mask[i]) oi = i;
                    check("xfer_idx", 64'(oi), 64'(e.idx));
                    check("xfer_word", 64'(mon_word), 64'(e.word));
                end
                le_len   = 0;
                mon_bits = 0;
            end
            prev_sclk  = pll_sclk;
            prev_sdata = pll_sdata;
        end
    end

    task automatic send(input logic [CMD_BIT_NUM-1:0] d, input logic [6:0] n,
                        input bit wr, input bit bad);
        int  r0;
        int  l0;
        int  blen;
        bit  done;
        xfer_t e;
        r0 = mon_rises;
        l0 = mon_les;
        if (wr) begin
            e.idx  = d[35:32];
            e.word = d[31:0];
            sb_q.push_back(e);
        end
        data     = d;
        data_num = n;
        dready   = 1'b1;
        step();
        check("ack_capture", 64'(ack), 64'd1);
        check("busy_capture", 64'(busy), 64'd1);
        dready = 1'b0;
        blen = 1;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            step();
            if (!busy) done = 1'b1;
            else blen++;
        end
        if (!done) fail_now("busy_timeout");
        check("busy_len", 64'(blen), wr ? 64'(WRITE_LEN) : 64'd1);
        if (bad && exp_err < 255) exp_err++;
        check("err_count", 64'(err_count), 64'(exp_err));
        step();
        check("ack_release", 64'(ack), 64'd0);
        check("sclk_rises", 64'(mon_rises - r0), wr ? 64'd32 : 64'd0);
        check("le_pulses", 64'(mon_les - l0), wr ? 64'd1 : 64'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int  r0;
        int  l0;
        bit  done;
        xfer_t e;

        vecs[0]  = '{41'h1_2_00400005, 7'd40, 1'b1, 1'b0};
        vecs[1]  = '{41'h0_0_00000008, 7'd4,  1'b0, 1'b0};
        vecs[2]  = '{41'h2_1_12345678, 7'd40, 1'b0, 1'b1};
        vecs[3]  = '{41'h1_7_DEADBEEF, 7'd40, 1'b0, 1'b1};
        vecs[4]  = '{41'h1_0_00000001, 7'd39, 1'b0, 1'b1};
        vecs[5]  = '{41'h1_0_A5A5F00F, 7'd40, 1'b1, 1'b0};
        vecs[6]  = '{41'h1_5_FFFFFFFF, 7'd40, 1'b1, 1'b0};
        vecs[7]  = '{41'h1_6_0000FFFF, 7'd40, 1'b0, 1'b1};
        vecs[8]  = '{41'h1_1_00000000, 7'd40, 1'b1, 1'b0};
        vecs[9]  = '{41'h1_3_12345678, 7'd41, 1'b0, 1'b1};
        vecs[10] = '{41'h1_3_0000000F, 7'd4,  1'b0, 1'b0};
        vecs[11] = '{41'h0_4_80000001, 7'd40, 1'b0, 1'b1};

        rst      = 1'b0;
        dready   = 1'b0;
        data     = '0;
        data_num = '0;
        repeat (3) step();
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sclk", 64'(pll_sclk), 64'd0);
        check("rst_sdata", 64'(pll_sdata), 64'd0);
        check("rst_le", 64'(pll_le), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 12; i++)
            send(vecs[i].d, vecs[i].n, vecs[i].wr, vecs[i].bad);

        // dready held well past the end of the transfer
        r0 = mon_rises;
        l0 = mon_les;
        e.idx  = 4'd3;
        e.word = 32'h13579BDF;
        sb_q.push_back(e);
        data     = 41'h1_3_13579BDF;
        data_num = 7'd40;
        dready   = 1'b1;
        step();
        check("held_ack_capture", 64'(ack), 64'd1);
        repeat (400) step();
        check("held_ack_high", 64'(ack), 64'd1);
        check("held_busy_low", 64'(busy), 64'd0);
        check("held_one_xfer", 64'(mon_les - l0), 64'd1);
        dready = 1'b0;
        step();
        check("held_ack_fall", 64'(ack), 64'd0);
        repeat (3) step();
        check("held_rises", 64'(mon_rises - r0), 64'd32);
        check("held_no_second", 64'(mon_les - l0), 64'd1);

        // reset after the 10th bit of a write to PLL 4
        l0       = mon_les;
        data     = 41'h1_4_CAFEF00D;
        data_num = 7'd40;
        dready   = 1'b1;
        step();
        dready = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            if (mon_bits >= 10) done = 1'b1;
            else step();
        end
        if (!done) fail_now("bit10_timeout");
        rst = 1'b0;
        step();
        check("mid_rst_sclk", 64'(pll_sclk), 64'd0);
        check("mid_rst_sdata", 64'(pll_sdata), 64'd0);
        check("mid_rst_le", 64'(pll_le), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ack", 64'(ack), 64'd0);
        check("mid_rst_err", 64'(err_count), 64'd0);
        exp_err = 0;
        step();
        rst = 1'b1;
        r0 = mon_rises;
        repeat (20) step();
        check("mid_rst_no_le", 64'(mon_les - l0), 64'd0);
        check("mid_rst_quiet", 64'(mon_rises - r0), 64'd0);
        send(41'h1_5_0F1E2D3C, 7'd40, 1'b1, 1'b0);

        // err_count saturation
        r0 = mon_rises;
        data     = 41'h1_9_00000000;
        data_num = 7'd40;
        for (int i = 0; i < 300; i++) begin
            dready = 1'b1;
            step();
            dready = 1'b0;
            step();
            if (exp_err < 255) exp_err++;
        end
        check("sat_err", 64'(err_count), 64'(exp_err));
        check("sat_err_255", 64'(err_count), 64'd255);
        check("sat_quiet", 64'(mon_rises - r0), 64'd0);

        repeat (5) step();
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
